rf_write_ctrl: RTL and testbench

Writeback controller for the 32x32 integer register file. It arbitrates NUM_REQ writeback requesters (ALU, LSU, ...) onto the file's single write port and keeps a per-register pending-write scoreboard, so decode stalls on RAW hazards until the producing write reaches the port. It sits between the execute/memory units and the register file; its registered write outputs drive the file's write port directly.

---
 rtl/rf_ctrl_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/rf_write_ctrl.sv | 155 +++++++++++++++
 tb/tb_rf_write_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared widths and types for the integer register-file writeback path.
package rf_ctrl_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// Writeback arbiter onto the register file's single write port, plus a
// per-register pending-write scoreboard used by decode for RAW stalls.
module rf_write_ctrl #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = rf_ctrl_pkg::DATA_W,
    parameter int unsigned ADDR_W  = rf_ctrl_pkg::ADDR_W,
    parameter int unsigned CNT_W   = rf_ctrl_pkg::CNT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid,
    input  logic [ADDR_W-1:0]               issue_rd,
    output logic                            issue_ready,
    input  logic [ADDR_W-1:0]               rs1,
    input  logic [ADDR_W-1:0]               rs2,
    output logic                            rs1_busy,
    output logic                            rs2_busy,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
    output logic                            rf_we,
    output logic [ADDR_W-1:0]               rf_waddr,
    output logic [DATA_W-1:0]               rf_wdata,
    output logic                            err
);

    import rf_ctrl_pkg::*;

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned NREGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  cnt_q [NREGS];
    logic [CNT_W-1:0]  cnt_d [NREGS];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic [PTR_W-1:0]   g_idx;
    logic               issue_fire;
    logic               retire;
    logic [NREGS-1:0]   inc_vec;
    logic [NREGS-1:0]   dec_vec;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign req_ready = rst ? '0 : grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        g_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i];
                sel_data = req_data[i];
                g_idx    = PTR_W'(i);
            end
        end
    end

    // Writes to x0 are consumed by the grant but never reach the port.
    always_comb begin
        ptr_d      = ptr_q;
        rf_we_d    = (|grant) && (sel_addr != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (|grant) begin
            ptr_d = (32'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;
        end
        if (rf_we_d) begin
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
        end
    end

    assign issue_ready = (issue_rd == '0) || (cnt_q[issue_rd] != CNT_MAX);
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
    assign retire      = rf_we_q && (rf_waddr_q != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_fire) inc_vec[issue_rd]   = 1'b1;
        if (retire)     dec_vec[rf_waddr_q] = 1'b1;
    end

    // Coincident issue and retire cancel; a retire against an empty counter
    // is flagged but leaves the counter at zero.
    always_comb begin
        err_d = err_q;
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                end else if (dec_vec[r]) begin
                    if (cnt_q[r] == '0) begin
                        err_d = 1'b1;
                    end else if (!inc_vec[r]) begin
                        cnt_d[r] = cnt_q[r] - CNT_ONE;
                    end
                end
            end
        end
    end

    // The file forwards its write port, so the final pending write is
    // already visible to readers during its write cycle.
    always_comb begin
        rs1_busy = (rs1 != '0) && (cnt_q[rs1] != '0) &&
                   !(rf_we_q && (rf_waddr_q == rs1) && (cnt_q[rs1] == CNT_ONE));
        rs2_busy = (rs2 != '0) && (cnt_q[rs2] != '0) &&
                   !(rf_we_q && (rf_waddr_q == rs2) && (cnt_q[rs2] == CNT_ONE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
            for (int unsigned r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
            for (int unsigned r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed bench for rf_write_ctrl: expected port writes are queued at grant
// time and checked by an independent monitor when rf_we appears.
module tb_rf_write_ctrl;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   issue_valid;
    logic [AW-1:0]          issue_rd;
    logic                   issue_ready;
    logic [AW-1:0]          rs1, rs2;
    logic                   rs1_busy, rs2_busy;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0][AW-1:0]  req_addr;
    logic [NR-1:0][DW-1:0]  req_data;
    logic                   rf_we;
    logic [AW-1:0]          rf_waddr;
    logic [DW-1:0]          rf_wdata;
    logic                   err;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    rf_write_ctrl #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    // Single write through requester 0; returns at the start of the write cycle.
    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid   = 2'b01;
        req_addr[0] = a;
        req_data[0] = d;
        #1;
        chk("grant_single", 32'(req_ready), 32'h1);
        push(a, d);
        tick();
        req_valid = '0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h want no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wb_addr", 32'(rf_waddr), 32'(e.a));
                chk("wb_data", rf_wdata, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_rd    = 5'd5;
        rs1         = 5'd5;
        rs2         = '0;
        req_valid   = 2'b11;
        req_addr    = '0;
        req_data    = '0;
        tick();
        tick();
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'h0);
        chk("rst_waddr", 32'(rf_waddr), 32'h0);
        chk("rst_wdata", rf_wdata, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_issue_ready", 32'(issue_ready), 32'h1);
        chk("rst_rs1_busy", 32'(rs1_busy), 32'h0);
        rst       = 1'b0;
        req_valid = '0;
        tick();

        // Issue x5, then write it back through the ALU port.
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        #1;
        chk("issue_ready_x5", 32'(issue_ready), 32'h1);
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd5;
        #1;
        chk("rs1_busy_after_issue", 32'(rs1_busy), 32'h1);
        wr0(5'd5, 32'h1234);
        #1;
        chk("rf_we_x5", 32'(rf_we), 32'h1);
        chk("rs1_busy_in_write_cycle", 32'(rs1_busy), 32'h0);
        tick();
        #1;
        chk("rs1_busy_after_retire", 32'(rs1_busy), 32'h0);

        // Requester 1 writes x0: consumed, no port write; pointer returns to 0.
        req_valid   = 2'b10;
        req_addr[1] = '0;
        req_data[1] = 32'hDEAD;
        #1;
        chk("grant_x0", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1;
        chk("x0_no_we", 32'(rf_we), 32'h0);

        // Round-robin with both requesters valid for four cycles.
        issue(5'd10);
        issue(5'd10);
        issue(5'd11);
        issue(5'd11);
        req_valid   = 2'b11;
        req_addr[0] = 5'd10;
        req_data[0] = 32'hA0;
        req_addr[1] = 5'd11;
        req_data[1] = 32'hB0;
        #1;
        chk("rr_grant0", 32'(req_ready), 32'h1);
        push(5'd10, 32'hA0);
        tick();
        req_data[0] = 32'hA1;
        #1;
        chk("rr_grant1", 32'(req_ready), 32'h2);
        push(5'd11, 32'hB0);
        tick();
        req_data[1] = 32'hB1;
        #1;
        chk("rr_grant2", 32'(req_ready), 32'h1);
        push(5'd10, 32'hA1);
        tick();
        #1;
        chk("rr_grant3", 32'(req_ready), 32'h2);
        push(5'd11, 32'hB1);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("rr_drained", 32'(exp_q.size()), 32'h0);
        chk("rr_no_err", 32'(err), 32'h0);

        // Saturate x7 and retire one of its writes.
        issue(5'd7);
        issue(5'd7);
        issue(5'd7);
        issue_rd = 5'd7;
        #1;
        chk("issue_ready_x7_full", 32'(issue_ready), 32'h0);
        issue_rd = 5'd8;
        #1;
        chk("issue_ready_x8", 32'(issue_ready), 32'h1);
        wr0(5'd7, 32'h77);
        issue_rd = 5'd7;
        rs2      = 5'd7;
        #1;
        chk("issue_ready_x7_during_retire", 32'(issue_ready), 32'h0);
        chk("rs2_busy_x7_during_retire", 32'(rs2_busy), 32'h1);
        tick();
        #1;
        chk("issue_ready_x7_after_retire", 32'(issue_ready), 32'h1);
        chk("rs2_busy_x7_after_retire", 32'(rs2_busy), 32'h1);

        // Issue x9 in the same cycle its only pending write retires.
        issue(5'd9);
        wr0(5'd9, 32'h99);
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        rs1         = 5'd9;
        #1;
        chk("issue_ready_x9_same_cycle", 32'(issue_ready), 32'h1);
        chk("rs1_busy_x9_same_cycle", 32'(rs1_busy), 32'h0);
        tick();
        issue_valid = 1'b0;
        #1;
        chk("rs1_busy_x9_after_edge", 32'(rs1_busy), 32'h1);
        wr0(5'd9, 32'h9A);
        #1;
        chk("rs1_busy_x9_last_write", 32'(rs1_busy), 32'h0);
        tick();
        #1;
        chk("rs1_busy_x9_clear", 32'(rs1_busy), 32'h0);
        chk("err_still_clear", 32'(err), 32'h0);

        // Retire to x3 with nothing pending sets the sticky error.
        wr0(5'd3, 32'h33);
        tick();
        #1;
        chk("err_set", 32'(err), 32'h1);
        tick();
        tick();
        chk("err_sticky", 32'(err), 32'h1);

        // Reset with writes in flight and cnt[4] = 2, pointer at 1.
        issue(5'd4);
        issue(5'd4);
        issue(5'd4);
        rs1         = 5'd4;
        issue_rd    = 5'd4;
        req_valid   = 2'b11;
        req_addr[0] = 5'd4;
        req_data[0] = 32'h40;
        req_addr[1] = 5'd4;
        req_data[1] = 32'h41;
        #1;
        chk("pre_rst_grant1", 32'(req_ready), 32'h2);
        push(5'd4, 32'h41);
        tick();
        #1;
        chk("pre_rst_grant0", 32'(req_ready), 32'h1);
        tick();
        #1;
        chk("pre_rst_pending_we", 32'(rf_we), 32'h1);
        chk("pre_rst_rs1_busy", 32'(rs1_busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rf_we", 32'(rf_we), 32'h0);
        chk("mid_rst_waddr", 32'(rf_waddr), 32'h0);
        chk("mid_rst_wdata", rf_wdata, 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_rs1_busy", 32'(rs1_busy), 32'h0);
        chk("mid_rst_issue_ready", 32'(issue_ready), 32'h1);
        tick();
        rst         = 1'b0;
        req_addr[0] = '0;
        req_addr[1] = '0;
        #1;
        chk("post_rst_ptr0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("post_rst_no_we", 32'(rf_we), 32'h0);
        chk("post_rst_err", 32'(err), 32'h0);
        tick();
        tick();
        chk("final_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
